// File: rtl/press_pattern_decoder.sv
// press_pattern_decoder
// Groups debounced single-cycle press pulses into gestures. Presses that
// arrive within WINDOW_CYCLES of each other belong to the same gesture.
// When the window expires with no press, the gesture's press count is reported
// with a one-cycle count_valid strobe.
// Optional feature: define PRESS_MODE_LATCH_EN to add a persistent 'mode'
// register. It is loaded with the count of each gesture that did not overflow.

module press_pattern_decoder #(
    parameter int WINDOW_CYCLES = 2700000,
    parameter int MAX_PRESSES   = 4,
    parameter int CNT_W         = $clog2(MAX_PRESSES + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             press,
    output logic [CNT_W-1:0] count_out,
    output logic             count_valid,
    output logic             overflow,
    output logic             busy
`ifdef PRESS_MODE_LATCH_EN
    ,
    output logic [CNT_W-1:0] mode
`endif
);

    localparam int TIMER_W = $clog2(WINDOW_CYCLES);

    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(WINDOW_CYCLES - 1);
    localparam logic [TIMER_W-1:0] TIMER_ZERO = '0;
    localparam logic [CNT_W-1:0]   COUNT_MAX  = CNT_W'(MAX_PRESSES);
    localparam logic [CNT_W-1:0]   COUNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]   COUNT_ZERO = '0;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        REPORT  = 2'd2
    } state_t;

    state_t             state;
    state_t             next_state;
    logic [CNT_W-1:0]   press_count;
    logic [CNT_W-1:0]   next_count;
    logic [TIMER_W-1:0] timer;
    logic [TIMER_W-1:0] next_timer;
    logic               ovf_flag;
    logic               next_ovf;

    // State, press counter, inactivity timer and overflow flag registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            press_count <= COUNT_ZERO;
            timer       <= TIMER_ZERO;
            ovf_flag    <= 1'b0;
        end else begin
            state       <= next_state;
            press_count <= next_count;
            timer       <= next_timer;
            ovf_flag    <= next_ovf;
        end
    end

    // Next-state logic. A press always wins over window expiry. A press during
    // REPORT starts a fresh gesture instead of being merged into the reported one.
    always_comb begin
        next_state = state;
        next_count = press_count;
        next_timer = timer;
        next_ovf   = ovf_flag;
        case (state)
            IDLE: begin
                if (press && enable) begin
                    next_state = COLLECT;
                    next_count = COUNT_ONE;
                    next_timer = TIMER_ZERO;
                    next_ovf   = 1'b0;
                end
            end
            COLLECT: begin
                if (!enable) begin
                    next_state = IDLE;
                    next_count = COUNT_ZERO;
                    next_timer = TIMER_ZERO;
                    next_ovf   = 1'b0;
                end else if (press) begin
                    if (press_count < COUNT_MAX) begin
                        next_count = press_count + COUNT_ONE;
                    end else begin
                        next_ovf = 1'b1;
                    end
                    next_timer = TIMER_ZERO;
                end else if (timer == TIMER_LAST) begin
                    next_state = REPORT;
                end else begin
                    next_timer = timer + 1'b1;
                end
            end
            REPORT: begin
                if (press && enable) begin
                    next_state = COLLECT;
                    next_count = COUNT_ONE;
                end else begin
                    next_state = IDLE;
                    next_count = COUNT_ZERO;
                end
                next_timer = TIMER_ZERO;
                next_ovf   = 1'b0;
            end
            default: begin
                next_state = IDLE;
                next_count = COUNT_ZERO;
                next_timer = TIMER_ZERO;
                next_ovf   = 1'b0;
            end
        endcase
    end

    // Report registers load on entry to REPORT, so the strobe coincides with
    // the REPORT cycle and the count/overflow values hold until the next report
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_valid <= 1'b0;
            count_out   <= COUNT_ZERO;
            overflow    <= 1'b0;
`ifdef PRESS_MODE_LATCH_EN
            mode        <= COUNT_ZERO;
`endif
        end else begin
            count_valid <= (next_state == REPORT);
            if (next_state == REPORT) begin
                count_out <= press_count;
                overflow  <= ovf_flag;
`ifdef PRESS_MODE_LATCH_EN
                if (!ovf_flag) begin
                    mode <= press_count;
                end
`endif
            end
        end
    end

    // Busy flags an in-progress gesture
    always_comb begin
        busy = (state == COLLECT);
    end

endmodule

// File: doc/press_pattern_decoder.md
Name: press_pattern_decoder

Overview:
- Consumes the single-cycle, synchronized, debounced press pulse produced by the button front-end (sync_debouncer).
- Groups pulses arriving within a programmable inactivity window into one gesture (single, double, triple, ... press).
- Emits the gesture's press count with a one-cycle valid strobe.
- Downstream acquisition control uses the count to select arm / start / dump / mode-cycle commands.

Parameters:
- WINDOW_CYCLES, 2700000: inactivity window in clk cycles (100 ms at 27 MHz). Legal range ≥ 2.
- MAX_PRESSES, 4: saturation value of the press counter. Legal range ≥ 1.
- CNT_W, $clog2(MAX_PRESSES+1): width of the count output. Derived; must not be overridden.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  synchronous active-low reset, sampled on posedge clk.
- enable  input  1  decoder enable; low aborts any gesture in progress.
- press  input  1  single-cycle press pulse (button_once).
- count_out  output  CNT_W  press count of the completed gesture; meaningful only while count_valid = 1.
- count_valid  output  1  one-cycle strobe marking a completed gesture.
- overflow  output  1  gesture exceeded MAX_PRESSES; qualified by count_valid.
- busy  output  1  high while a gesture is being collected (state COLLECT).

Behaviour:
- Reset and clocking:
  - One clock domain (clk). Reset is synchronous, active-low (rst_n).
  - Reset values: count_out = 0, count_valid = 0, overflow = 0, busy = 0, state = IDLE, internal counter and timer = 0.
- Timer:
  - Width is $clog2(WINDOW_CYCLES).
  - Counter holds 0..MAX_PRESSES; it never wraps.
- FSM: IDLE, COLLECT, REPORT.
- IDLE:
  - press & enable → COLLECT, count = 1, timer = 0, ovf flag = 0.
  - press while enable = 0 is ignored.
- COLLECT (busy = 1):
  - press:
    - If count < MAX_PRESSES: count += 1.
    - Else: count holds at MAX_PRESSES and the ovf flag is set.
    - In both cases timer = 0.
  - No press and timer == WINDOW_CYCLES-1 → REPORT.
  - Otherwise timer += 1.
- REPORT (one cycle):
  - count_valid = 1, count_out = count, overflow = ovf flag.
  - Next state is IDLE.
  - If press & enable in this cycle: next state COLLECT with count = 1, timer = 0, ovf flag cleared. The press is not lost and not merged into the reported gesture.
- Latency: count_valid is high in cycle N+WINDOW_CYCLES+1, where cycle N is the one in which the last press of the gesture was high.
- Output hold: count_out and overflow are registered alongside count_valid and hold their value after the strobe until the next REPORT. count_valid is never high two consecutive cycles.
- enable deasserted:
  - In COLLECT: next state IDLE, no report, count and timer cleared.
  - In REPORT: the strobe still completes.
- Simultaneous press and timer expiry in COLLECT: press wins. The count increments and the timer restarts; no report that cycle.
- rst_n low mid-gesture: all state is cleared at that edge; no strobe for the aborted gesture.
- Presses spaced by exactly WINDOW_CYCLES cycles (press in cycle N, next press in cycle N+WINDOW_CYCLES) join the same gesture. Spacing ≥ WINDOW_CYCLES+1 yields separate gestures.

Optional Feature:
- Macro: PRESS_MODE_LATCH_EN.
- When defined:
  - Adds output port mode [CNT_W-1:0], reset 0.
  - On each count_valid without overflow, mode is loaded with count_out. An overflowing gesture leaves mode unchanged.
  - mode holds between reports and provides a persistent command register for downstream logic.
- When undefined: the port and its register do not exist; all other behaviour is identical.

Test Plan (WINDOW_CYCLES = 16, MAX_PRESSES = 4):
- Reset, then one press in cycle 10 with enable = 1 → busy high from cycle 11; count_valid = 1, count_out = 1, overflow = 0 in cycle 27 only; busy low in cycle 27.
- Presses in cycles 10, 20, 36 → single strobe in cycle 53 with count_out = 3. Repeat with spacing 17 (cycles 10, 27) → two strobes, each with count_out = 1.
- Six presses 5 cycles apart → count_out = 4, overflow = 1 on the strobe. With PRESS_MODE_LATCH_EN, mode is unchanged from its prior value.
- Press coinciding with the REPORT cycle → that strobe carries the old count; a new gesture starts and reports count_out = 1 seventeen cycles later.
- Two presses, then enable = 0 in the 5th cycle after the 2nd press → no strobe, busy low next cycle. Same sequence with rst_n = 0 instead → identical result and all outputs reset.
- PRESS_MODE_LATCH_EN: gestures of 2 then 3 presses → mode = 2 after the first strobe, 3 after the second. A press with enable = 0 in IDLE → no activity.
